ser_xchg_ctrl: RTL and testbench



---
 rtl/ser_xchg_pkg.sv | 33 +++
 rtl/ser_xchg_arb.sv | 29 ++
 rtl/ser_xchg_ctrl.sv | 135 +++++++++++++
 tb/tb_ser_xchg_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_xchg_pkg.sv
// Shared types and constants for the serial exchange controller.
// The round-robin pick helper lives here so the arbiter and any future user agree on it.
package ser_xchg_pkg;

    localparam int XCHG_BITS = 8;
    localparam int CNT_BITS  = $clog2(XCHG_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        CPU  = 1'b0,
        LINK = 1'b1
    } owner_t;

    // On a tie the requester that was not granted last wins.
    function automatic owner_t rr_pick(owner_t last_grant, logic cpu_req, logic link_req);
        owner_t pick;
        pick = last_grant;
        if (cpu_req && link_req)
            pick = (last_grant == LINK) ? CPU : LINK;
        else if (cpu_req)
            pick = CPU;
        else if (link_req)
            pick = LINK;
        return pick;
    endfunction

endpackage

// File: rtl/ser_xchg_arb.sv
// Two-way round-robin arbiter between the CPU window and the link engine.
// last_grant only moves when a transfer completes, not when it is granted.
module ser_xchg_arb
    import ser_xchg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic link_req,
    input  logic update,
    input  logic upd_link,
    output logic any_req,
    output logic grant_link
);

    owner_t last_grant;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= LINK;
        else if (update)
            last_grant <= owner_t'(upd_link);
    end

    assign any_req    = cpu_req | link_req;
    assign grant_link = (rr_pick(last_grant, cpu_req, link_req) == LINK);

endmodule

// File: rtl/ser_xchg_ctrl.sv
// Shares one 8-bit full-duplex serial exchange channel between the CPU bus window
// and the link engine; sequences IDLE -> SETUP -> 8x SHIFT -> DONE per transfer.
module ser_xchg_ctrl
    import ser_xchg_pkg::*;
#(
    parameter logic [3:0] WIN_CMD   = 4'h2,
    parameter logic [7:0] READ_FILL = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SSER,
    input  logic [13:4] BA,
    input  logic        BR_W,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait,
    input  logic        link_req,
    input  logic        link_we,
    input  logic [7:0]  link_wdata,
    output logic        link_ack,
    output logic [7:0]  link_rdata,
    output logic        sdr_shift,
    output logic        sdr_sin,
    input  logic        sdr_sout,
    output logic        sdr_we
);

    state_t                state, state_next;
    owner_t                owner, owner_next;
    logic [XCHG_BITS-1:0]  sr;
    logic [XCHG_BITS-1:0]  load_data;
    logic                  load_we;
    logic                  wr_flag;
    logic [CNT_BITS-1:0]   cnt;
    logic                  cpu_hit, cpu_req, cpu_served;
    logic                  any_req, grant_link;
    logic                  done_cpu;
    logic                  unused_ba;

    // BA[11:8] are outside the window decode.
    assign unused_ba = ^BA[11:8];

    assign cpu_hit  = ~SSER & ~BA[13] & BA[12] & (BA[7:4] == WIN_CMD);
    assign cpu_req  = cpu_hit & ~cpu_served;
    assign done_cpu = (state == DONE) && (owner == CPU);

    ser_xchg_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .link_req   (link_req),
        .update     (state == DONE),
        .upd_link   (owner == LINK),
        .any_req    (any_req),
        .grant_link (grant_link)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_next = owner_t'(grant_link);
                    state_next = SETUP;
                end
            end
            SETUP:   state_next = SHIFT;
            SHIFT:   if (cnt == CNT_BITS'(XCHG_BITS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_data = READ_FILL;
        load_we   = 1'b0;
        if (owner == CPU) begin
            load_data = BR_W ? READ_FILL : cpu_wdata;
            load_we   = ~BR_W;
        end else begin
            load_data = link_we ? link_wdata : READ_FILL;
            load_we   = link_we;
        end
    end

    // NOTE: the captured-byte registers are reset because software may read them before any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= CPU;
            sr         <= '0;
            wr_flag    <= 1'b0;
            cnt        <= '0;
            cpu_rdata  <= '0;
            link_rdata <= '0;
            cpu_served <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            case (state)
                SETUP: begin
                    sr      <= load_data;
                    wr_flag <= load_we;
                    cnt     <= '0;
                end
                SHIFT: begin
                    sr  <= {sr[XCHG_BITS-2:0], sdr_sout};
                    cnt <= cnt + CNT_BITS'(1);
                end
                DONE: begin
                    if (owner == CPU)
                        cpu_rdata <= sr;
                    else
                        link_rdata <= sr;
                end
                default: ;
            endcase
            // An aborted CPU access (window dropped mid-transfer) never marks itself served.
            if (!cpu_hit)
                cpu_served <= 1'b0;
            else if (done_cpu)
                cpu_served <= 1'b1;
        end
    end

    // Strobes decode straight from flops, so they drop the instant reset asserts.
    assign sdr_shift = (state == SHIFT);
    assign sdr_sin   = (state == SHIFT) & sr[XCHG_BITS-1];
    assign sdr_we    = (state == SHIFT) & wr_flag;
    assign link_ack  = (state == DONE) && (owner == LINK);
    assign cpu_wait  = ~rst & cpu_hit & ~cpu_served & ~done_cpu;

endmodule

// File: tb/tb_ser_xchg_ctrl.sv
// Directed bench for ser_xchg_ctrl: a window-decode vector table plus hand-built
// transfer sequences against a simple serial-register model that returns a fixed byte.
module tb_ser_xchg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sser;
    logic [9:0] ba;
    logic       br_w;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       cpu_wait;
    logic       link_req, link_we;
    logic [7:0] link_wdata, link_rdata;
    logic       link_ack;
    logic       sdr_shift, sdr_sin, sdr_sout, sdr_we;

    localparam logic [9:0] BA_HIT = 10'b01_0000_0010;

    ser_xchg_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .SSER       (sser),
        .BA         (ba),
        .BR_W       (br_w),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_wait   (cpu_wait),
        .link_req   (link_req),
        .link_we    (link_we),
        .link_wdata (link_wdata),
        .link_ack   (link_ack),
        .link_rdata (link_rdata),
        .sdr_shift  (sdr_shift),
        .sdr_sin    (sdr_sin),
        .sdr_sout   (sdr_sout),
        .sdr_we     (sdr_we)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-sequence observation log, cleared at the start of each sequence.
    int         cyc, wait_cnt, wait_fall_cyc, ack_cnt, ack_cyc, we_cnt, nshift, dev_idx;
    logic       prev_wait, auto_drop;
    logic [7:0] sin_log, dev_byte;

    typedef struct {
        string      name;
        logic       sser;
        logic [9:0] ba;
        logic       exp_wait;
    } dec_vec_t;

    dec_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0; wait_cnt = 0; wait_fall_cyc = 0; ack_cnt = 0; ack_cyc = 0;
        we_cnt = 0; nshift = 0; dev_idx = 0; prev_wait = 1'b0; sin_log = 8'h00;
    endtask

    // One clock: observe at the falling edge and play the external serial register.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (cpu_wait) wait_cnt++;
        if (!cpu_wait && prev_wait) wait_fall_cyc = cyc;
        prev_wait = cpu_wait;
        if (link_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
            if (auto_drop) link_req = 1'b0;
        end
        if (sdr_shift) begin
            sin_log = {sin_log[6:0], sdr_sin};
            if (sdr_we) we_cnt++;
            nshift++;
            sdr_sout = (dev_idx < 8) ? dev_byte[7 - dev_idx] : 1'b0;
            dev_idx++;
        end else begin
            dev_idx = 0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Align just after a rising edge so the first logged cycle is the IDLE cycle.
    task automatic start_window();
        @(posedge clk);
        #1;
        clear_log();
    endtask

    task automatic cpu_open(input logic rd, input logic [7:0] wdat);
        br_w = rd; cpu_wdata = wdat; ba = BA_HIT; sser = 1'b0;
    endtask

    task automatic cpu_close();
        sser = 1'b1;
        steps(2);
    endtask

    initial begin
        vecs[0] = '{"hit_base",   1'b0, 10'b01_0000_0010, 1'b1};
        vecs[1] = '{"sser_high",  1'b1, 10'b01_0000_0010, 1'b0};
        vecs[2] = '{"ba13_high",  1'b0, 10'b11_0000_0010, 1'b0};
        vecs[3] = '{"ba12_low",   1'b0, 10'b00_0000_0010, 1'b0};
        vecs[4] = '{"cmd_3",      1'b0, 10'b01_0000_0011, 1'b0};
        vecs[5] = '{"hit_mid_f",  1'b0, 10'b01_1111_0010, 1'b1};
        vecs[6] = '{"cmd_a",      1'b0, 10'b01_0000_1010, 1'b0};
        vecs[7] = '{"hit_mid_5",  1'b0, 10'b01_0101_0010, 1'b1};

        rst = 1'b1; sser = 1'b1; ba = '0; br_w = 1'b1; cpu_wdata = '0;
        link_req = 1'b0; link_we = 1'b0; link_wdata = '0; sdr_sout = 1'b0;
        auto_drop = 1'b1; dev_byte = 8'h00;
        clear_log();
        steps(2);

        // Reset state, including cpu_wait forced low while the window is hit.
        check("rst_cpu_rdata",  {24'h0, cpu_rdata},  32'h00);
        check("rst_link_rdata", {24'h0, link_rdata}, 32'h00);
        check("rst_strobes", {28'h0, sdr_shift, sdr_sin, sdr_we, link_ack}, 32'h0);
        sser = 1'b0; ba = BA_HIT; #1;
        check("rst_wait_forced", {31'h0, cpu_wait}, 32'h0);
        sser = 1'b1;
        rst = 1'b0;
        steps(2);

        // Window decode table; the window is closed again before each rising edge.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sser = vecs[i].sser; ba = vecs[i].ba; #1;
            check({"dec_", vecs[i].name}, {31'h0, cpu_wait}, {31'h0, vecs[i].exp_wait});
            sser = 1'b1;
        end
        steps(2);

        // CPU write A5, device returns 3C.
        start_window();
        dev_byte = 8'h3C; cpu_open(1'b0, 8'hA5);
        steps(14);
        check("wr_sin_seq",   {24'h0, sin_log},   32'hA5);
        check("wr_we_cnt",    we_cnt,             32'd8);
        check("wr_nshift",    nshift,             32'd8);
        check("wr_wait_cnt",  wait_cnt,           32'd10);
        check("wr_cpu_rdata", {24'h0, cpu_rdata}, 32'h3C);
        cpu_close();

        // CPU read with the window held: fill byte out, single transfer only.
        start_window();
        dev_byte = 8'h5A; cpu_open(1'b1, 8'h00);
        steps(24);
        check("rd_sin_seq",   {24'h0, sin_log},   32'hFF);
        check("rd_we_cnt",    we_cnt,             32'd0);
        check("rd_nshift",    nshift,             32'd8);
        check("rd_wait_cnt",  wait_cnt,           32'd10);
        check("rd_cpu_rdata", {24'h0, cpu_rdata}, 32'h5A);
        cpu_close();

        // Tie with the CPU granted last: link goes first, CPU waits through both.
        start_window();
        dev_byte = 8'h96; auto_drop = 1'b1;
        link_we = 1'b0; link_req = 1'b1;
        cpu_open(1'b0, 8'h0F);
        steps(28);
        check("tieA_ack_cyc",   ack_cyc,             32'd11);
        check("tieA_wait_cnt",  wait_cnt,            32'd21);
        check("tieA_cpu_after", wait_fall_cyc - ack_cyc, 32'd11);
        check("tieA_link_rd",   {24'h0, link_rdata}, 32'h96);
        check("tieA_last_sin",  {24'h0, sin_log},    32'h0F);
        cpu_close();

        // Tie right after reset: CPU first, link DONE exactly 11 cycles after CPU DONE.
        rst = 1'b1; steps(2); rst = 1'b0; steps(1);
        start_window();
        dev_byte = 8'hC3; auto_drop = 1'b1;
        link_we = 1'b1; link_wdata = 8'h22; link_req = 1'b1;
        cpu_open(1'b0, 8'h11);
        steps(30);
        check("tieB_wait_cnt",  wait_cnt,                32'd10);
        check("tieB_cpu_done",  wait_fall_cyc,           32'd11);
        check("tieB_ack_gap",   ack_cyc - wait_fall_cyc, 32'd11);
        check("tieB_ack_cnt",   ack_cnt,                 32'd1);
        check("tieB_nshift",    nshift,                  32'd16);
        check("tieB_link_sin",  {24'h0, sin_log},        32'h22);
        check("tieB_cpu_rd",    {24'h0, cpu_rdata},      32'hC3);
        cpu_close();

        // Link write 81, request dropped on ack: one pulse, no extra transfer.
        start_window();
        dev_byte = 8'h7E; auto_drop = 1'b1;
        link_we = 1'b1; link_wdata = 8'h81; link_req = 1'b1;
        steps(25);
        check("lw_ack_cnt", ack_cnt,             32'd1);
        check("lw_ack_cyc", ack_cyc,             32'd11);
        check("lw_sin",     {24'h0, sin_log},    32'h81);
        check("lw_we_cnt",  we_cnt,              32'd8);
        check("lw_nshift",  nshift,              32'd8);
        check("lw_rdata",   {24'h0, link_rdata}, 32'h7E);

        // Held link request is not filtered: back-to-back transfers, 11 cycles apart.
        start_window();
        dev_byte = 8'hE7; auto_drop = 1'b0;
        link_we = 1'b0; link_req = 1'b1;
        steps(22);
        link_req = 1'b0;
        steps(4);
        check("held_ack_cnt", ack_cnt,             32'd2);
        check("held_ack_cyc", ack_cyc,             32'd22);
        check("held_nshift",  nshift,              32'd16);
        check("held_rdata",   {24'h0, link_rdata}, 32'hE7);

        // Reset during SHIFT cycle 4 of a link write.
        start_window();
        dev_byte = 8'h00; auto_drop = 1'b0;
        link_we = 1'b1; link_wdata = 8'hF0; link_req = 1'b1;
        steps(6);
        check("rst4_in_shift", {31'h0, sdr_shift}, 32'h1);
        rst = 1'b1; #1;
        check("rst4_strobes", {29'h0, sdr_shift, sdr_sin, sdr_we}, 32'h0);
        check("rst4_rdata",   {16'h0, cpu_rdata, link_rdata},      32'h0);
        link_req = 1'b0;
        steps(2);
        rst = 1'b0;
        steps(12);
        check("rst4_no_ack", ack_cnt, 32'd0);
        start_window();
        dev_byte = 8'h42; cpu_open(1'b0, 8'h69);
        steps(14);
        check("rst4_fresh_wait",  wait_cnt,           32'd10);
        check("rst4_fresh_sin",   {24'h0, sin_log},   32'h69);
        check("rst4_fresh_rdata", {24'h0, cpu_rdata}, 32'h42);
        cpu_close();

        // CPU window dropped mid-SHIFT: framing completes, rdata updates, no stall.
        start_window();
        dev_byte = 8'hB4; cpu_open(1'b1, 8'h00);
        steps(6);
        sser = 1'b1;
        steps(10);
        check("abort_nshift",   nshift,             32'd8);
        check("abort_wait_cnt", wait_cnt,           32'd6);
        check("abort_rdata",    {24'h0, cpu_rdata}, 32'hB4);
        check("abort_wait_now", {31'h0, cpu_wait},  32'h0);
        sser = 1'b0; #1;
        check("abort_not_served", {31'h0, cpu_wait}, 32'h1);
        steps(14);
        cpu_close();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
